// File: rtl/id_decode_stage_pkg.sv
// Shared pipeline definitions: opcodes, ALUOp encodings, control bundle layouts
// and the main decoder used by the ID stage.
package id_decode_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned CTRL_WB_W = 2;
    localparam int unsigned CTRL_M_W  = 3;
    localparam int unsigned CTRL_EX_W = 4;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } ctrl_wb_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic [ALUOP_W-1:0]  alu_op;
    } ctrl_ex_t;

    typedef struct packed {
        ctrl_wb_t wb;
        ctrl_m_t  m;
        ctrl_ex_t ex;
    } ctrl_t;

    // Main control decoder; unknown opcodes decode to an all-zero bundle.
    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_RTYPE: begin
                c.ex.reg_dst   = 1'b1;
                c.wb.reg_write = 1'b1;
                c.ex.alu_op    = ALUOP_FUNCT;
            end
            OPC_LW: begin
                c.ex.alu_src    = 1'b1;
                c.wb.mem_to_reg = 1'b1;
                c.wb.reg_write  = 1'b1;
                c.m.mem_read    = 1'b1;
                c.ex.alu_op     = ALUOP_ADD;
            end
            OPC_SW: begin
                c.ex.alu_src  = 1'b1;
                c.m.mem_write = 1'b1;
                c.ex.alu_op   = ALUOP_ADD;
            end
            OPC_BEQ: begin
                c.m.branch  = 1'b1;
                c.ex.alu_op = ALUOP_SUB;
            end
            OPC_ADDI: begin
                c.ex.alu_src   = 1'b1;
                c.wb.reg_write = 1'b1;
                c.ex.alu_op    = ALUOP_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Opcodes that consume rs as a source operand.
    function automatic logic opc_reads_rs(input logic [OPC_W-1:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_LW) || (opc == OPC_SW) ||
               (opc == OPC_BEQ)   || (opc == OPC_ADDI);
    endfunction

    // Opcodes that consume rt as a source operand (rt is a destination otherwise).
    function automatic logic opc_reads_rt(input logic [OPC_W-1:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_SW) || (opc == OPC_BEQ);
    endfunction

endpackage

// File: rtl/id_decode_stage_reg_file.sv
// 32x32 register file: r0 hard-wired to zero, combinational reads with
// write-through from the write-back port.
module reg_file
    import id_decode_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wr_en_c;
    logic            byp1_c;
    logic            byp2_c;

    assign wr_en_c = we_i && (waddr_i != '0);

    // Reset clears the array and takes priority over a same-cycle write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[REG_AW'(i)] <= '0;
            end
        end else if (wr_en_c) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign byp1_c = wr_en_c && (waddr_i == raddr1_i);
    assign byp2_c = wr_en_c && (waddr_i == raddr2_i);

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = byp1_c ? wdata_i : regs_q[raddr1_i];
        end
        if (raddr2_i != '0) begin
            rdata2_o = byp2_c ? wdata_i : regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: register read, sign extension, main control decode,
// load-use hazard detection with bubble insertion and a saturating stall counter.
module id_decode_stage
    import id_decode_stage_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [XLEN-1:0]      Instruction_in,
    input  logic                 RegWrite_WB,
    input  logic [REG_AW-1:0]    WriteReg_WB,
    input  logic [XLEN-1:0]      WriteData_WB,
    input  logic                 MemRead_IDEX,
    input  logic [REG_AW-1:0]    Rt_IDEX,
    output logic [XLEN-1:0]      ReadData1,
    output logic [XLEN-1:0]      ReadData2,
    output logic [XLEN-1:0]      SignExtend,
    output logic [REG_AW-1:0]    Rs,
    output logic [REG_AW-1:0]    Rt,
    output logic [REG_AW-1:0]    Rd,
    output logic [CTRL_WB_W-1:0] control_WB,
    output logic [CTRL_M_W-1:0]  control_M,
    output logic [CTRL_EX_W-1:0] control_EX,
    output logic                 Stall,
    output logic [XLEN-1:0]      StallCount
);

    logic [OPC_W-1:0] opcode_c;
    ctrl_t            ctrl_c;
    logic             stall_c;
    logic [XLEN-1:0]  stall_count_q;
    logic [XLEN-1:0]  stall_count_d;

    assign opcode_c = Instruction_in[31:26];
    assign Rs       = Instruction_in[25:21];
    assign Rt       = Instruction_in[20:16];
    assign Rd       = Instruction_in[15:11];

    assign SignExtend = {{(XLEN-16){Instruction_in[15]}}, Instruction_in[15:0]};

    reg_file u_reg_file (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .we_i     (RegWrite_WB),
        .waddr_i  (WriteReg_WB),
        .wdata_i  (WriteData_WB),
        .raddr1_i (Instruction_in[25:21]),
        .raddr2_i (Instruction_in[20:16]),
        .rdata1_o (ReadData1),
        .rdata2_o (ReadData2)
    );

    // Load-use hazard: only source operands of a recognised opcode can conflict.
    always_comb begin
        stall_c = 1'b0;
        if (MemRead_IDEX && (Rt_IDEX != '0)) begin
            if (opc_reads_rs(opcode_c) && (Rt_IDEX == Rs)) begin
                stall_c = 1'b1;
            end
            if (opc_reads_rt(opcode_c) && (Rt_IDEX == Rt)) begin
                stall_c = 1'b1;
            end
        end
    end

    assign Stall = stall_c;

    // Bubble: zero every control bit while stalled.
    always_comb begin
        ctrl_c = decode_ctrl(opcode_c);
        if (stall_c) begin
            ctrl_c = '0;
        end
    end

    assign control_WB = ctrl_c.wb;
    assign control_M  = ctrl_c.m;
    assign control_EX = ctrl_c.ex;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != {XLEN{1'b1}})) begin
            stall_count_d = stall_count_q + XLEN'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: inputs change on the falling edge and
// outputs are compared shortly after, well before the next rising edge.
module tb_id_decode_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instruction_in;
    logic        RegWrite_WB;
    logic [4:0]  WriteReg_WB;
    logic [31:0] WriteData_WB;
    logic        MemRead_IDEX;
    logic [4:0]  Rt_IDEX;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] SignExtend;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [1:0]  control_WB;
    logic [2:0]  control_M;
    logic [3:0]  control_EX;
    logic        Stall;
    logic [31:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    id_decode_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Instruction_in (Instruction_in),
        .RegWrite_WB    (RegWrite_WB),
        .WriteReg_WB    (WriteReg_WB),
        .WriteData_WB   (WriteData_WB),
        .MemRead_IDEX   (MemRead_IDEX),
        .Rt_IDEX        (Rt_IDEX),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .SignExtend     (SignExtend),
        .Rs             (Rs),
        .Rt             (Rt),
        .Rd             (Rd),
        .control_WB     (control_WB),
        .control_M      (control_M),
        .control_EX     (control_EX),
        .Stall          (Stall),
        .StallCount     (StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    initial begin
        Reset          = 1'b1;
        Instruction_in = '0;
        RegWrite_WB    = 1'b0;
        WriteReg_WB    = '0;
        WriteData_WB   = '0;
        MemRead_IDEX   = 1'b0;
        Rt_IDEX        = '0;

        // Reset, then r5 reads zero
        repeat (2) @(negedge Clk);
        Reset          = 1'b0;
        Instruction_in = r_type(5'd5, 5'd0, 5'd0);
        #1;
        check("reset_r5", ReadData1, 32'h0);
        check("reset_stallcount", StallCount, 32'h0);
        check("reset_stall", {31'd0, Stall}, 32'h0);

        // Writes to r0 are ignored, including write-through
        @(negedge Clk);
        RegWrite_WB    = 1'b1;
        WriteReg_WB    = 5'd0;
        WriteData_WB   = 32'hDEAD;
        Instruction_in = r_type(5'd0, 5'd0, 5'd0);
        #1;
        check("r0_bypass", ReadData1, 32'h0);
        @(negedge Clk);
        RegWrite_WB = 1'b0;
        #1;
        check("r0_after_write", ReadData1, 32'h0);

        // Write-through of r8 on both read ports, then persistence
        @(negedge Clk);
        RegWrite_WB    = 1'b1;
        WriteReg_WB    = 5'd8;
        WriteData_WB   = 32'h12345678;
        Instruction_in = r_type(5'd8, 5'd8, 5'd1);
        #1;
        check("r8_bypass_rd1", ReadData1, 32'h12345678);
        check("r8_bypass_rd2", ReadData2, 32'h12345678);
        @(negedge Clk);
        RegWrite_WB  = 1'b0;
        WriteData_WB = 32'h0;
        #1;
        check("r8_persist", ReadData1, 32'h12345678);

        // lw decode and sign extension
        @(negedge Clk);
        Instruction_in = 32'h8C090004;
        #1;
        check("lw_wb", {30'd0, control_WB}, 32'h3);
        check("lw_m", {29'd0, control_M}, 32'h2);
        check("lw_ex", {28'd0, control_EX}, 32'h4);
        check("lw_se_pos", SignExtend, 32'h4);
        check("lw_rs", {27'd0, Rs}, 32'd0);
        check("lw_rt", {27'd0, Rt}, 32'd9);
        Instruction_in = 32'h8C09FFFC;
        #1;
        check("lw_se_neg", SignExtend, 32'hFFFFFFFC);

        // Load-use on rs with a simultaneous write-back to r12
        @(negedge Clk);
        MemRead_IDEX   = 1'b1;
        Rt_IDEX        = 5'd9;
        Instruction_in = r_type(5'd9, 5'd11, 5'd10);
        RegWrite_WB    = 1'b1;
        WriteReg_WB    = 5'd12;
        WriteData_WB   = 32'hCAFEF00D;
        #1;
        check("lu_stall", {31'd0, Stall}, 32'h1);
        check("lu_bubble", {23'd0, control_WB, control_M, control_EX}, 32'h0);
        check("lu_rd_field", {27'd0, Rd}, 32'd10);
        check("lu_rs_field", {27'd0, Rs}, 32'd9);
        @(negedge Clk);
        RegWrite_WB    = 1'b0;
        Rt_IDEX        = 5'd0;
        Instruction_in = r_type(5'd12, 5'd11, 5'd10);
        #1;
        check("lu_count", StallCount, 32'd1);
        check("rt0_no_stall", {31'd0, Stall}, 32'h0);
        check("r_wb", {30'd0, control_WB}, 32'h2);
        check("r_m", {29'd0, control_M}, 32'h0);
        check("r_ex", {28'd0, control_EX}, 32'hA);
        check("write_during_stall", ReadData1, 32'hCAFEF00D);

        // rt conflicts stall only for opcodes that read rt
        @(negedge Clk);
        Rt_IDEX        = 5'd11;
        Instruction_in = r_type(5'd12, 5'd11, 5'd10);
        #1;
        check("r_rt_stall", {31'd0, Stall}, 32'h1);
        @(negedge Clk);
        Instruction_in = i_type(6'b001000, 5'd0, 5'd11, 16'd5);
        #1;
        check("count_two", StallCount, 32'd2);
        check("addi_no_stall", {31'd0, Stall}, 32'h0);
        check("addi_ctrl", {23'd0, control_WB, control_M, control_EX}, {23'd0, 2'b10, 3'b000, 4'b0100});
        Instruction_in = i_type(6'b101011, 5'd0, 5'd11, 16'd0);
        #1;
        check("sw_rt_stall", {31'd0, Stall}, 32'h1);
        MemRead_IDEX = 1'b0;
        #1;
        check("sw_noread_stall", {31'd0, Stall}, 32'h0);
        check("sw_ctrl", {23'd0, control_WB, control_M, control_EX}, {23'd0, 2'b00, 3'b001, 4'b0100});

        // Unknown opcode: no control, no stall even with matching fields
        @(negedge Clk);
        check("count_hold", StallCount, 32'd2);
        MemRead_IDEX   = 1'b1;
        Rt_IDEX        = 5'd9;
        Instruction_in = {6'b111111, 5'd9, 5'd9, 5'd9, 11'h7FF};
        #1;
        check("unk_ctrl", {23'd0, control_WB, control_M, control_EX}, 32'h0);
        check("unk_stall", {31'd0, Stall}, 32'h0);

        // Stall counter saturation from a preloaded value
        @(negedge Clk);
        Instruction_in = r_type(5'd9, 5'd11, 5'd10);
        force dut.stall_count_q = 32'hFFFFFFFD;
        #1;
        release dut.stall_count_q;
        #1;
        check("sat_preload", StallCount, 32'hFFFFFFFD);
        @(negedge Clk);
        #1;
        check("sat_fe", StallCount, 32'hFFFFFFFE);
        @(negedge Clk);
        #1;
        check("sat_ff", StallCount, 32'hFFFFFFFF);
        @(negedge Clk);
        #1;
        check("sat_hold", StallCount, 32'hFFFFFFFF);

        // Mid-operation reset with stall and write active: reset wins
        @(negedge Clk);
        Reset          = 1'b1;
        RegWrite_WB    = 1'b1;
        WriteReg_WB    = 5'd7;
        WriteData_WB   = 32'h55AA55AA;
        @(negedge Clk);
        Reset          = 1'b0;
        RegWrite_WB    = 1'b0;
        MemRead_IDEX   = 1'b0;
        Instruction_in = r_type(5'd8, 5'd7, 5'd0);
        #1;
        check("rst_count", StallCount, 32'h0);
        check("rst_r8", ReadData1, 32'h0);
        check("rst_r7", ReadData2, 32'h0);
        @(negedge Clk);
        #1;
        check("post_rst_count", StallCount, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 The block SHALL have exactly one clock, Clk  in  1  (all state updates on rising edge).
REQ-002 Reset  in  1  SHALL be synchronous and active-high.
REQ-003 Instruction_in  in  32  SHALL carry the instruction from the IF/ID register.
REQ-004 RegWrite_WB  in  1  SHALL be the write-back write enable.
REQ-005 WriteReg_WB  in  5  SHALL be the write-back destination register.
REQ-006 WriteData_WB  in  32  SHALL be the write-back data.
REQ-007 MemRead_IDEX  in  1  SHALL be the MemRead bit currently held in ID/EX, used for load-use detection.
REQ-008 Rt_IDEX  in  5  SHALL be the rt field currently held in ID/EX.
REQ-009 ReadData1, ReadData2  out  32 each SHALL be the rs and rt register contents.
REQ-010 SignExtend  out  32 SHALL be Instruction_in[15:0] sign-extended.
REQ-011 Rs, Rt, Rd  out  5 each SHALL be Instruction_in[25:21], [20:16] and [15:11].
REQ-012 Control outputs SHALL be as follows:
- control_WB  out  2  = {RegWrite, MemtoReg}
- control_M  out  3  = {Branch, MemRead, MemWrite}
- control_EX  out  4  = {RegDst, ALUSrc, ALUOp[1:0]}
REQ-013 Stall  out  1 SHALL, when high, tell IF to hold the PC and the IF/ID register.
REQ-014 StallCount  out  32 SHALL be a performance counter of stall cycles.

Function
REQ-015 The register file SHALL hold 32x32 bits; register 0 SHALL read 0 always, and writes to it SHALL be ignored.
REQ-016 A write SHALL occur on the rising Clk edge when RegWrite_WB=1, WriteReg_WB!=0 and Reset=0.
REQ-017 Reads SHALL be combinational. When RegWrite_WB=1, WriteReg_WB!=0 and WriteReg_WB equals the register being read, the read SHALL return WriteData_WB in the same cycle (write-through).
REQ-018 Decode SHALL use opcode Instruction_in[31:26]:
- 000000 (R): RegDst=1, RegWrite=1, ALUOp=10
- 100011 (lw): ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00
- 101011 (sw): ALUSrc=1, MemWrite=1, ALUOp=00
- 000100 (beq): Branch=1, ALUOp=01
- 001000 (addi): ALUSrc=1, RegWrite=1, ALUOp=00
- any other opcode: all control bits 0
REQ-019 Stall SHALL be 1 combinationally when MemRead_IDEX=1, Rt_IDEX!=0, and either Rt_IDEX==Rs, or (Rt_IDEX==Rt and the opcode is R, sw or beq).
REQ-020 While Stall=1, control_WB, control_M and control_EX SHALL be forced to 0 (bubble); data and field outputs SHALL be unaffected.
REQ-021 StallCount SHALL increment by 1 on each rising edge with Stall=1 and Reset=0, and SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-022 Latency: decode outputs SHALL be combinational (0 cycles); a write SHALL be visible to a normal read on the cycle after the edge, or on the same cycle via REQ-017.
REQ-023 A simultaneous write and stall SHALL both take effect; the write SHALL not be suppressed by Stall.

Reset
REQ-024 On a rising edge with Reset=1, all 32 registers and StallCount SHALL clear to 0, and any write or stall-count in that cycle SHALL be discarded (reset wins).
REQ-025 Reset asserted mid-operation SHALL behave identically to REQ-024; combinational outputs SHALL reflect the cleared state on the following cycle.

Structure
REQ-026 Opcode constants, ALUOp encodings and control-bundle widths SHALL live in a shared package used by all pipeline stages.
REQ-027 The register file SHALL be a separate sub-module, reg_file, containing REQ-015 to REQ-017; decode, hazard and counter logic SHALL stay in id_decode_stage.

Verification
REQ-028 The bench SHALL cover reset and register 0:
- Reset 1 cycle, then read r5 -> 0.
- Write r0=32'hDEAD -> r0 reads 0.
REQ-029 The bench SHALL cover writing r8=32'h12345678 with Instruction_in rs=8 in the same cycle -> ReadData1=32'h12345678 that cycle (bypass), and it SHALL persist next cycle.
REQ-030 The bench SHALL cover lw 32'h8C090004 -> control_WB=2'b11, control_M=3'b010, control_EX=4'b0100, SignExtend=4; then 16'hFFFC immediate -> SignExtend=32'hFFFFFFFC.
REQ-031 The bench SHALL cover load-use: MemRead_IDEX=1, Rt_IDEX=9, add $10,$9,$11 -> Stall=1, all control bits 0, StallCount +1; with Rt_IDEX=0 -> Stall=0.
REQ-032 The bench SHALL cover the stall counter: preload StallCount near 32'hFFFFFFFF and hold Stall 3 cycles -> it saturates at 32'hFFFFFFFF; then Reset -> 0.
REQ-033 The bench SHALL cover unknown opcode 6'b111111 -> all control 0 and Stall=0 regardless of fields.
